// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector-side peers.
package seq_pkg;

  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] DEF_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_pattern_tx_piso.sv
// Parallel-in/serial-out shift register; shifts left with zero fill, MSB is the serial tap.
module seq_pattern_tx_piso #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] shreg_q;

  // Load wins over shift so a back-to-back frame reloads on its last-bit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (clr_i) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with optional idle gaps.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = seq_pkg::PAT_W,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  import seq_pkg::*;

  localparam int unsigned BIT_W = $clog2(PAT_W);

  seq_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             valid_q, busy_q, done_q;
  logic             ld, sh, clr;
  logic [PAT_W-1:0] ld_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      frame_q <= '0;
      gcnt_q  <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      gcnt_q  <= gcnt_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      valid_q <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state, counter updates and shift-register controls.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    gcnt_d  = gcnt_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    ld      = 1'b0;
    sh      = 1'b0;
    clr     = 1'b0;
    ld_data = pat_q;

    if (abort_i) begin
      state_d = IDLE;
      bit_d   = '0;
      frame_d = '0;
      gcnt_d  = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (repeat_n_i != '0) begin
              pat_d   = pattern_i;
              gap_d   = gap_i;
              frame_d = repeat_n_i;
              bit_d   = BIT_W'(PAT_W - 1);
              ld      = 1'b1;
              ld_data = pattern_i;
              state_d = SHIFT;
            end else begin
              state_d = DONE;
            end
          end
        end
        SHIFT: begin
          sh    = 1'b1;
          bit_d = bit_q - BIT_W'(1);
          if (bit_q == '0) begin
            if (frame_q <= CNT_W'(1)) begin
              bit_d   = '0;
              frame_d = '0;
              state_d = DONE;
            end else begin
              frame_d = frame_q - CNT_W'(1);
              bit_d   = BIT_W'(PAT_W - 1);
              if (gap_q == '0) begin
                ld = 1'b1;
              end else begin
                gcnt_d  = gap_q;
                state_d = GAP;
              end
            end
          end
        end
        GAP: begin
          if (gcnt_q <= GAP_W'(1)) begin
            gcnt_d  = '0;
            ld      = 1'b1;
            state_d = SHIFT;
          end else begin
            gcnt_d = gcnt_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          bit_d   = '0;
          frame_d = '0;
          gcnt_d  = '0;
          clr     = 1'b1;
        end
      endcase
    end
  end

  seq_pattern_tx_piso #(
    .PAT_W (PAT_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .load_i  (ld),
    .shift_i (sh),
    .data_i  (ld_data),
    .msb_o   (out_o)
  );

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: cycle-by-cycle traces compared to hand-derived vectors.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic [3:0] pattern_i;
  logic [3:0] repeat_n_i;
  logic [3:0] gap_i;
  logic       out_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tv, to, tb, td, tm;
  logic        acc;

  seq_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .pattern_i  (pattern_i),
    .repeat_n_i (repeat_n_i),
    .gap_i      (gap_i),
    .out_o      (out_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] gp);
    start_i    = 1'b1;
    pattern_i  = pat;
    repeat_n_i = rep;
    gap_i      = gp;
  endtask

  // Runs n cycles after the accepting edge; first cycle lands in the MSB of the n-bit trace.
  // start stays high (with scrambled operands) for the first 'hold' cycles.
  // m collects 1011-detector hits, bit i set when the i-th valid bit completes a match.
  task automatic capture(input int n, input int hold,
                         output logic [31:0] v, output logic [31:0] o,
                         output logic [31:0] b, output logic [31:0] d,
                         output logic [31:0] m);
    logic [3:0] hist;
    int         idx;
    v = '0; o = '0; b = '0; d = '0; m = '0;
    hist = '0;
    idx  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start_i    = (i < hold);
      pattern_i  = 4'b0010;
      repeat_n_i = 4'hF;
      gap_i      = 4'h3;
      v = {v[30:0], valid_o};
      o = {o[30:0], out_o};
      b = {b[30:0], busy_o};
      d = {d[30:0], done_o};
      if (valid_o) begin
        hist = {hist[2:0], out_o};
        idx++;
        if (hist == 4'b1011) m = m | (32'd1 << idx);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    pattern_i  = '0;
    repeat_n_i = '0;
    gap_i      = '0;

    #3;
    chk("rst_out",   32'(out_o),   32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_done",  32'(done_o),  32'd0);
    #9 rst = 1'b1;
    tick();

    // single frame, no gap
    launch(4'b1011, 4'd1, 4'd0);
    capture(6, 0, tv, to, tb, td, tm);
    chk("t1_valid", tv, 32'b111100);
    chk("t1_out",   to, 32'b101100);
    chk("t1_busy",  tb, 32'b111110);
    chk("t1_done",  td, 32'b000010);

    // two frames back-to-back, checked through a 1011 detector
    launch(4'b1011, 4'd2, 4'd0);
    capture(10, 0, tv, to, tb, td, tm);
    chk("t2_valid", tv, 32'b1111111100);
    chk("t2_out",   to, 32'b1011101100);
    chk("t2_busy",  tb, 32'b1111111110);
    chk("t2_done",  td, 32'b0000000010);
    chk("t2_det",   tm, 32'h0000_0110);

    // three frames with a 2-cycle gap
    launch(4'b1011, 4'd3, 4'd2);
    capture(18, 0, tv, to, tb, td, tm);
    chk("t3_valid", tv, 32'b111100111100111100);
    chk("t3_out",   to, 32'b101100101100101100);
    chk("t3_busy",  tb, 32'b111111111111111110);
    chk("t3_done",  td, 32'b000000000000000010);
    chk("t3_nvalid", 32'($countones(tv)), 32'd12);
    chk("t3_nbusy",  32'($countones(tb)), 32'd17);

    // zero repeat count
    launch(4'b1011, 4'd0, 4'd0);
    capture(3, 0, tv, to, tb, td, tm);
    chk("t4_valid", tv, 32'b000);
    chk("t4_out",   to, 32'b000);
    chk("t4_busy",  tb, 32'b100);
    chk("t4_done",  td, 32'b100);

    // start held mid-burst and operands changed right after acceptance
    launch(4'b1101, 4'd1, 4'd0);
    capture(6, 3, tv, to, tb, td, tm);
    chk("t5_valid", tv, 32'b111100);
    chk("t5_out",   to, 32'b110100);
    chk("t5_busy",  tb, 32'b111110);
    chk("t5_done",  td, 32'b000010);

    // abort beats start in IDLE
    launch(4'b1011, 4'd1, 4'd0);
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("t6_prio_busy",  32'(busy_o),  32'd0);
    chk("t6_prio_valid", 32'(valid_o), 32'd0);

    // abort during bit 2 of frame 1
    launch(4'b1011, 4'd2, 4'd0);
    tick();
    start_i = 1'b0;
    chk("t7_bit1", {30'd0, valid_o, out_o}, 32'b11);
    tick();
    chk("t7_bit2", {30'd0, valid_o, out_o}, 32'b10);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t7_abort", {28'd0, out_o, valid_o, busy_o, done_o}, 32'd0);
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc = acc | done_o | busy_o | valid_o;
    end
    chk("t7_quiet", 32'(acc), 32'd0);

    // asynchronous reset in the middle of a gap
    launch(4'b1011, 4'd3, 4'd3);
    capture(5, 0, tv, to, tb, td, tm);
    chk("t8_in_gap", {28'd0, out_o, valid_o, busy_o, done_o}, 32'b0010);
    #2 rst = 1'b0;
    #1;
    chk("t8_rst", {28'd0, out_o, valid_o, busy_o, done_o}, 32'd0);
    tick();
    chk("t8_rst_hold", {28'd0, out_o, valid_o, busy_o, done_o}, 32'd0);
    rst = 1'b1;
    tick();
    launch(4'b1011, 4'd1, 4'd0);
    capture(6, 0, tv, to, tb, td, tm);
    chk("t8_valid", tv, 32'b111100);
    chk("t8_out",   to, 32'b101100);
    chk("t8_busy",  tb, 32'b111110);
    chk("t8_done",  td, 32'b000010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
